// File: rtl/modo_ctrl.sv
// Lock mode controller: routes keypad packets to the operational or setup side and owns the committed config.
// cfg layout (MSB..LSB): bip_status[1] | bip_time[7] | tranca_aut_time[7] | senha_master[80] | senha_1..senha_4[80 each].
module modo_ctrl #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [79:0]  digitos_value,
    input  logic         digitos_valid,
    output logic [79:0]  op_digitos_value,
    output logic         op_digitos_valid,
    input  logic         op_display_en,
    input  logic [23:0]  op_bcd_pac,
    output logic         setup_on,
    output logic [79:0]  setup_digitos_value,
    output logic         setup_digitos_valid,
    input  logic         setup_display_en,
    input  logic [23:0]  setup_bcd_pac,
    input  logic [414:0] data_setup_new,
    input  logic         data_setup_ok,
    output logic [414:0] cfg,
    output logic         cfg_updated,
    output logic         setup_mode,
    output logic         display_en,
    output logic [23:0]  bcd_pac
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 32'd1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [79:0]   FLUSH_PKT = {20{4'hB}};
    localparam logic [79:0]   NO_PWD    = {20{4'hF}};
    localparam logic [414:0]  CFG_RST   = {1'b1, 7'd5, 7'd5, {64'hFFFF_FFFF_FFFF_FFFF, 16'h1234},
                                           NO_PWD, NO_PWD, NO_PWD, NO_PWD};

    // NORMAL: packets go to op side | ENTER: setup_on pulse | SETUP: packets go to setup side
    // FLUSH: inject save packet     | DRAIN: swallow aborted result | COMMIT: cfg_updated pulse
    typedef enum logic [2:0] {NORMAL, ENTER, SETUP, FLUSH, DRAIN, COMMIT} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  idle_cnt;
    logic [1:0]     drain_cnt;
    logic           master_hit;

    assign master_hit = (digitos_value == cfg[399:320]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= NORMAL;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: if (digitos_valid && master_hit) state_nxt = ENTER;
            ENTER:  state_nxt = SETUP;
            SETUP: begin
                if (data_setup_ok)                           state_nxt = COMMIT;
                else if (!digitos_valid && idle_cnt == CNT_LAST) state_nxt = FLUSH;
            end
            FLUSH:  state_nxt = DRAIN;
            DRAIN:  if (data_setup_ok || drain_cnt == 2'd3) state_nxt = NORMAL;
            COMMIT: state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_digitos_value    <= '0;
            op_digitos_valid    <= 1'b0;
            setup_on            <= 1'b0;
            setup_digitos_value <= '0;
            setup_digitos_valid <= 1'b0;
            cfg                 <= CFG_RST;
            cfg_updated         <= 1'b0;
            idle_cnt            <= '0;
            drain_cnt           <= '0;
        end else begin
            op_digitos_valid    <= 1'b0;
            setup_on            <= 1'b0;
            setup_digitos_valid <= 1'b0;
            cfg_updated         <= 1'b0;
            case (state)
                NORMAL: begin
                    if (digitos_valid) begin
                        if (master_hit) begin
                            setup_on <= 1'b1;
                        end else begin
                            op_digitos_value <= digitos_value;
                            op_digitos_valid <= 1'b1;
                        end
                    end
                end
                ENTER: idle_cnt <= '0;
                SETUP: begin
                    // a result arriving alongside a key closes the session; the key is dropped
                    if (data_setup_ok) begin
                        cfg         <= data_setup_new;
                        cfg_updated <= 1'b1;
                    end else if (digitos_valid) begin
                        setup_digitos_value <= digitos_value;
                        setup_digitos_valid <= 1'b1;
                        idle_cnt            <= '0;
                    end else begin
                        if (idle_cnt == CNT_LAST) begin
                            setup_digitos_value <= FLUSH_PKT;
                            setup_digitos_valid <= 1'b1;
                        end
                        if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                FLUSH: drain_cnt <= '0;
                DRAIN: drain_cnt <= drain_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign setup_mode = (state != NORMAL);
    assign display_en = setup_mode ? setup_display_en : op_display_en;
    assign bcd_pac    = setup_mode ? setup_bcd_pac    : op_bcd_pac;

endmodule
